instr_mem_loader: RTL and testbench

Word-addressed instruction memory with a byte-serial boot loader, sitting directly upstream of the instruction fetch unit. It consumes the fetch unit's 30-bit word PC, and returns the 32-bit instruction combinationally so the single-cycle datapath closes in one clock. After reset it accepts a program image byte-by-byte over a valid/ready port. It then releases the processor by raising `cpu_run`.

---
 rtl/instr_mem_pkg.sv | 13 +
 rtl/word_packer.sv | 45 ++++
 rtl/instr_mem_loader.sv | 121 ++++++++++++
 tb/tb_instr_mem_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the boot-loaded instruction memory.
// The optional checksum output is enabled by defining INSTR_MEM_CHECKSUM_EN.
package instr_mem_pkg;

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam logic [29:0] BASE_PC_DEF = 30'h0100008;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

endpackage

// File: rtl/word_packer.sv
// Packs loader bytes big-endian into 32-bit words and strobes a commit on the
// fourth byte of a word or on the image's final byte (lower lanes zero-filled).
module word_packer (
    input  logic        clk,
    input  logic        rstb,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        commit_o
);

    logic [1:0]  cnt_q;
    logic [23:0] lanes_q;

    // Current byte is merged into its lane; lanes below it read as zero so a
    // short final word comes out already padded.
    always_comb begin
        word_o = 32'h0;
        case (cnt_q)
            2'd0: word_o = {byte_i, 24'h0};
            2'd1: word_o = {lanes_q[23:16], byte_i, 16'h0};
            2'd2: word_o = {lanes_q[23:8], byte_i, 8'h0};
            2'd3: word_o = {lanes_q, byte_i};
            default: word_o = 32'h0;
        endcase
    end

    assign commit_o = accept_i & ((cnt_q == 2'd3) | last_i);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cnt_q   <= 2'd0;
            lanes_q <= 24'h0;
        end else if (accept_i) begin
            lanes_q <= word_o[31:8];
            if (commit_o) begin
                cnt_q <= 2'd0;
            end else begin
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Word-addressed instruction memory filled by a byte-serial boot loader, then
// read combinationally by the fetch PC. Checksum: define INSTR_MEM_CHECKSUM_EN.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [29:0] BASE_PC    = BASE_PC_DEF
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [29:0] current_pc,
    output logic [31:0] instr,
    output logic        pc_fault,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_overflow,
    output logic        cpu_run,
    output logic [31:0] ld_checksum
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_e                state_q;
    logic                  cpu_run_q;
    logic                  overflow_q;
    logic [DEPTH_LOG2:0]   wr_ptr_q;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic [31:0]           pk_word;
    logic                  pk_commit;
    logic                  ptr_full;

    assign ld_ready = (state_q == S_LOAD);
    assign accept   = ld_valid & ld_ready;
    assign ptr_full = (wr_ptr_q == PTR_FULL);

    word_packer u_packer (
        .clk      (clk),
        .rstb     (rstb),
        .accept_i (accept),
        .byte_i   (ld_byte),
        .last_i   (ld_last),
        .word_o   (pk_word),
        .commit_o (pk_commit)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= S_LOAD;
            cpu_run_q  <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    // A full memory saturates the pointer; further words are dropped.
                    if (pk_commit) begin
                        if (ptr_full) begin
                            overflow_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end
                    end
                    if (accept && ld_last) begin
                        state_q   <= S_RUN;
                        cpu_run_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    state_q   <= S_RUN;
                    cpu_run_q <= 1'b1;
                end
                default: begin
                    state_q   <= S_LOAD;
                    cpu_run_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage is deliberately not reset; the window compare hides stale words.
    always_ff @(posedge clk) begin
        if (pk_commit && !ptr_full) begin
            mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= pk_word;
        end
    end

    logic [29:0] idx;
    logic [29:0] ptr_ext;
    logic        in_window;

    assign idx       = current_pc - BASE_PC;
    assign ptr_ext   = {{(30 - DEPTH_LOG2 - 1){1'b0}}, wr_ptr_q};
    assign in_window = (idx < ptr_ext);

    assign instr       = (cpu_run_q && in_window) ? mem[idx[DEPTH_LOG2-1:0]] : NOP_INSTR;
    assign pc_fault    = cpu_run_q & ~in_window;
    assign cpu_run     = cpu_run_q;
    assign ld_overflow = overflow_q;

`ifdef INSTR_MEM_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            csum_q <= 32'h0;
        end else if (pk_commit && !ptr_full) begin
            csum_q <= csum_q + pk_word;
        end
    end

    assign ld_checksum = csum_q;
`else
    assign ld_checksum = 32'h0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: full-depth and 4-word instances share stimulus.
module tb_instr_mem_loader;
    import instr_mem_pkg::*;

    localparam logic [29:0] BASE = 30'h0100008;

    logic        clk;
    logic        rstb;
    logic [29:0] current_pc;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;

    logic [31:0] instr, instr_s;
    logic        pc_fault, pc_fault_s;
    logic        ld_ready, ld_ready_s;
    logic        ld_overflow, ld_overflow_s;
    logic        cpu_run, cpu_run_s;
    logic [31:0] ld_checksum, ld_checksum_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  img_q[$];

    instr_mem_loader #(.DEPTH_LOG2(10), .BASE_PC(BASE)) dut (
        .clk(clk), .rstb(rstb), .current_pc(current_pc), .instr(instr),
        .pc_fault(pc_fault), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_overflow(ld_overflow),
        .cpu_run(cpu_run), .ld_checksum(ld_checksum)
    );

    instr_mem_loader #(.DEPTH_LOG2(2), .BASE_PC(BASE)) dut_s (
        .clk(clk), .rstb(rstb), .current_pc(current_pc), .instr(instr_s),
        .pc_fault(pc_fault_s), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_last(ld_last), .ld_ready(ld_ready_s), .ld_overflow(ld_overflow_s),
        .cpu_run(cpu_run_s), .ld_checksum(ld_checksum_s)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb     = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_byte  = 8'h00;
        repeat (2) @(negedge clk);
        rstb = 1'b1;
    endtask

    // Valid/ready: a byte transfers on a rising edge where ld_valid and ld_ready are both high.
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        @(posedge clk);
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic send_image(input bit gaps);
        foreach (img_q[i]) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(img_q[i], (i == img_q.size() - 1));
        end
    endtask

    // Reads every expected word through the fetch port, then the first PC past the window.
    task automatic verify_image(input string tag);
        foreach (exp_q[i]) begin
            current_pc = BASE + 30'(i);
            #1;
            check_eq({tag, "_word"}, instr, exp_q[i]);
        end
        current_pc = BASE + 30'(exp_q.size());
        #1;
        check_eq({tag, "_past_instr"}, instr, NOP_INSTR);
        check_eq({tag, "_past_fault"}, {31'b0, pc_fault}, 32'd1);
    endtask

    initial begin
        rstb       = 1'b1;
        current_pc = BASE;
        ld_valid   = 1'b0;
        ld_byte    = 8'h00;
        ld_last    = 1'b0;

        // reset state
        do_reset();
        #1;
        check_eq("rst_ready",    {31'b0, ld_ready},    32'd1);
        check_eq("rst_cpu_run",  {31'b0, cpu_run},     32'd0);
        check_eq("rst_overflow", {31'b0, ld_overflow}, 32'd0);
        check_eq("rst_checksum", ld_checksum,          32'h0);
        check_eq("rst_instr",    instr,                32'h0);
        check_eq("rst_fault",    {31'b0, pc_fault},    32'd0);

        // single word, ld_last on the 4th byte
        img_q = '{8'h8C, 8'h01, 8'h00, 8'h04};
        send_image(0);
        check_eq("w1_cpu_run", {31'b0, cpu_run},  32'd1);
        check_eq("w1_ready",   {31'b0, ld_ready}, 32'd0);
        current_pc = BASE;
        #1;
        check_eq("w1_instr", instr,             32'h8C010004);
        check_eq("w1_fault", {31'b0, pc_fault}, 32'd0);
`ifdef INSTR_MEM_CHECKSUM_EN
        check_eq("w1_checksum", ld_checksum, 32'h8C010004);
`else
        check_eq("w1_checksum", ld_checksum, 32'h0);
`endif
        exp_q = '{32'h8C010004};
        verify_image("w1");

        // ld_valid in S_RUN must not extend the image
        @(negedge clk);
        send_byte(8'h77, 1'b0);
        current_pc = BASE + 30'd1;
        #1;
        check_eq("run_ignore_fault", {31'b0, pc_fault}, 32'd1);

        // six bytes, partial final word
        do_reset();
        img_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        exp_q = '{32'h11223344, 32'h55660000};
        send_image(0);
        verify_image("six");
`ifdef INSTR_MEM_CHECKSUM_EN
        check_eq("six_checksum", ld_checksum, 32'h66883344);
`endif

        // same image with random gaps on ld_valid
        do_reset();
        send_image(1);
        check_eq("gap_cpu_run", {31'b0, cpu_run}, 32'd1);
        verify_image("gap");

        // five words: small instance overflows, large one holds all five
        do_reset();
        img_q = {};
        for (int i = 1; i <= 20; i++) img_q.push_back(8'(i));
        exp_q = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
        send_image(0);
        check_eq("ovf_small", {31'b0, ld_overflow_s}, 32'd1);
        check_eq("ovf_big",   {31'b0, ld_overflow},   32'd0);
        verify_image("ovf_big");
        current_pc = BASE + 30'd3;
        #1;
        check_eq("ovf_small_w3", instr_s, 32'h0D0E0F10);
        current_pc = BASE + 30'd4;
        #1;
        check_eq("ovf_small_w4",    instr_s,              32'h0);
        check_eq("ovf_small_fault", {31'b0, pc_fault_s},  32'd1);
`ifdef INSTR_MEM_CHECKSUM_EN
        check_eq("ovf_small_sum", ld_checksum_s, 32'h1C202428);
        check_eq("ovf_big_sum",   ld_checksum,   32'h2D32373C);
`else
        check_eq("ovf_small_sum", ld_checksum_s, 32'h0);
`endif

        // reset mid-load after three bytes, then a fresh word
        do_reset();
        current_pc = BASE;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        #1;
        check_eq("load_instr", instr,             32'h0);
        check_eq("load_fault", {31'b0, pc_fault}, 32'd0);
        @(negedge clk);
        rstb = 1'b0;
        #1;
        check_eq("midrst_cpu_run", {31'b0, cpu_run},  32'd0);
        check_eq("midrst_ready",   {31'b0, ld_ready}, 32'd1);
        @(negedge clk);
        rstb = 1'b1;
        img_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_q = '{32'hDEADBEEF};
        send_image(0);
        check_eq("midrst_run", {31'b0, cpu_run}, 32'd1);
        verify_image("midrst");

        // PC below base underflows the subtract
        current_pc = 30'h00FFFFF;
        #1;
        check_eq("below_instr", instr,             32'h0);
        check_eq("below_fault", {31'b0, pc_fault}, 32'd1);

        // asynchronous reset while running
        @(posedge clk);
        #2;
        rstb = 1'b0;
        #1;
        check_eq("runrst_cpu_run", {31'b0, cpu_run},  32'd0);
        check_eq("runrst_fault",   {31'b0, pc_fault}, 32'd0);
        @(negedge clk);
        rstb = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
